// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among N_REQ writeback sources,
// with a per-register pending-write scoreboard for RAW hazard detection at issue.
module regfile_wb_arbiter #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*5-1:0]      req_addr,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  output logic                    WE3,
  output logic [4:0]              A3,
  output logic [XLEN-1:0]         WD3,
  input  logic                    mark_en,
  input  logic [4:0]              mark_addr,
  input  logic [4:0]              qry_a1,
  input  logic [4:0]              qry_a2,
  output logic                    busy1,
  output logic                    busy2
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   scan_s;
  logic [PW-1:0]   gidx_s;
  logic [PW-1:0]   ptr_nxt_s;
  logic            found_s;
  logic [4:0]      gaddr_s;
  logic [XLEN-1:0] gdata_s;
  logic [31:0]     busy_r;
  logic [31:0]     busy_nxt_s;

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    scan_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_s = PW'((int'(ptr_r) + k) % N_REQ);
      if (!found_s && req_valid[scan_s]) begin
        found_s = 1'b1;
        gidx_s  = scan_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winner's payload and the pointer position just past it.
  always_comb begin
    gaddr_s   = req_addr[5*int'(gidx_s) +: 5];
    gdata_s   = req_data[XLEN*int'(gidx_s) +: XLEN];
    ptr_nxt_s = (gidx_s == PW'(N_REQ - 1)) ? '0 : gidx_s + PW'(1);
  end

  // One-hot ready; forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (found_s && !rst) begin
      req_ready[gidx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Write-port register and round-robin pointer; x0 grants are accepted but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
      WE3   <= 1'b0;
      A3    <= 5'd0;
      WD3   <= '0;
    end else if (found_s) begin
      ptr_r <= ptr_nxt_s;
      WE3   <= (gaddr_s != 5'd0);
      A3    <= gaddr_s;
      WD3   <= gdata_s;
    end else begin
      WE3   <= 1'b0;
    end
  end

  // Scoreboard next state: clear on commit first, so a same-edge mark wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (WE3) begin
      busy_nxt_s[A3] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (mark_en && (mark_addr != 5'd0)) begin
      busy_nxt_s[mark_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy1 = busy_r[qry_a1];
  assign busy2 = busy_r[qry_a2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;
  localparam int N  = 2;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_addr;
  logic [N*XL-1:0] req_data;
  logic            WE3;
  logic [4:0]      A3;
  logic [XL-1:0]   WD3;
  logic            mark_en;
  logic [4:0]      mark_addr, qry_a1, qry_a2;
  logic            busy1, busy2;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .WE3(WE3), .A3(A3), .WD3(WD3),
    .mark_en(mark_en), .mark_addr(mark_addr), .qry_a1(qry_a1), .qry_a2(qry_a2),
    .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  int          m_ptr;
  bit          m_we;
  bit [4:0]    m_a3;
  bit [XL-1:0] m_wd;
  bit [31:0]   m_busy;
  logic [N-1:0] g_ready;
  int          last_w;

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_a3 = 5'd0; m_wd = '0; m_busy = 32'd0;
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_busy_of(input logic [4:0] r);
    return (r == 5'd0) ? 1'b0 : m_busy[r];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [XL-1:0] d);
    req_valid[i]       = v;
    req_addr[5*i +: 5] = a;
    req_data[XL*i +: XL] = d;
  endtask

  // One clock: check combinational outputs, step the model at the edge, check registers.
  task automatic cyc();
    int w;
    logic [N-1:0] er;
    bit [31:0] nb;
    bit [4:0] wa;
    #1;
    w  = m_winner();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    g_ready = req_ready;
    last_w  = w;
    chk("ready", req_ready, er);
    chk("busy1", busy1, m_busy_of(qry_a1));
    chk("busy2", busy2, m_busy_of(qry_a2));
    nb = m_busy;
    if (m_we) nb[m_a3] = 1'b0;
    if (mark_en && mark_addr != 5'd0) nb[mark_addr] = 1'b1;
    nb[0] = 1'b0;
    if (w >= 0) begin
      wa    = req_addr[5*w +: 5];
      m_we  = (wa != 5'd0);
      m_a3  = wa;
      m_wd  = req_data[XL*w +: XL];
      m_ptr = (w + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    m_busy = nb;
    #1;
    chk("WE3", WE3, m_we);
    chk("A3", A3, m_a3);
    chk("WD3", WD3, m_wd);
  endtask

  int wait_cnt [N];

  initial begin
    rst = 1'b1; req_valid = '1; req_addr = '0; req_data = '0;
    mark_en = 1'b0; mark_addr = 5'd0; qry_a1 = 5'd0; qry_a2 = 5'd0;
    model_reset();
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_WE3", WE3, 1'b0);
    chk("rst_A3", A3, 5'd0);
    chk("rst_WD3", WD3, 32'd0);
    req_valid = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a write, with a busy register outstanding
    set_req(0, 1'b1, 5'd3, 32'hA5A5_0003);
    mark_en = 1'b1; mark_addr = 5'd9;
    cyc();
    mark_en = 1'b0;
    qry_a1 = 5'd9; qry_a2 = 5'd9;
    #1;
    chk("mid_busy1", busy1, 1'b1);
    chk("mid_WE3", WE3, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_WE3", WE3, 1'b0);
    chk("async_A3", A3, 5'd0);
    chk("async_WD3", WD3, 32'd0);
    chk("async_busy1", busy1, 1'b0);
    chk("async_busy2", busy2, 1'b0);
    chk("async_ready", req_ready, 2'b00);
    req_valid = '0;
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Contention: alternating grants starting at requester 0
    set_req(0, 1'b1, 5'd10, 32'h0000_1010);
    set_req(1, 1'b1, 5'd11, 32'h0000_1111);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("cont_gnt", g_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("cont_WE3", WE3, 1'b1);
      chk("cont_A3", A3, (k % 2 == 0) ? 5'd10 : 5'd11);
      chk("cont_WD3", WD3, (k % 2 == 0) ? 32'h0000_1010 : 32'h0000_1111);
    end
    req_valid = '0;

    // x0 write is accepted but dropped; scoreboard untouched
    mark_en = 1'b1; mark_addr = 5'd20;
    cyc();
    mark_en = 1'b0;
    qry_a1 = 5'd20; qry_a2 = 5'd0;
    set_req(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    cyc();
    chk("x0_ready", g_ready, 2'b01);
    chk("x0_WE3", WE3, 1'b0);
    chk("x0_busy1", busy1, 1'b1);
    req_valid = '0;
    cyc();
    chk("x0_busy_hold", busy1, 1'b1);

    // Scoreboard: busy stays up through the WE3 cycle, drops after
    mark_en = 1'b1; mark_addr = 5'd5;
    cyc();
    mark_en = 1'b0;
    qry_a1 = 5'd5;
    #1;
    chk("sb_busy_set", busy1, 1'b1);
    set_req(1, 1'b1, 5'd5, 32'h0000_1234);
    cyc();
    req_valid = '0;
    chk("sb_WE3", WE3, 1'b1);
    chk("sb_A3", A3, 5'd5);
    chk("sb_busy_commit", busy1, 1'b1);
    cyc();
    chk("sb_busy_clr", busy1, 1'b0);

    // Collision: mark x7 on the edge that commits x7
    set_req(0, 1'b1, 5'd7, 32'h0000_0777);
    cyc();
    req_valid = '0;
    mark_en = 1'b1; mark_addr = 5'd7; qry_a2 = 5'd7;
    chk("col_A3", A3, 5'd7);
    cyc();
    mark_en = 1'b0;
    chk("col_busy", busy2, 1'b1);
    cyc();
    chk("col_busy_after", busy2, 1'b1);

    // Randomized traffic with held payloads and starvation checks
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) != 0))
          set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      mark_addr = 5'($urandom_range(0, 31));
      mark_en   = ($urandom_range(0, 3) == 0) && !m_busy_of(mark_addr);
      qry_a1    = 5'($urandom_range(0, 31));
      qry_a2    = 5'($urandom_range(0, 31));
      cyc();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_w != i) begin
          wait_cnt[i]++;
          chk("no_starve", wait_cnt[i] < N, 1'b1);
        end else begin
          wait_cnt[i] = 0;
        end
      end
      if (last_w >= 0) req_valid[last_w] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
